// File: rtl/inst_pkg.sv
// Instruction-set constants, loader FSM states and the ID-to-byte encoder
// shared by the program loader and its neighbours.
package inst_pkg;

   localparam logic [3:0] ID_2  = 4'd2;
   localparam logic [3:0] ID_4  = 4'd4;
   localparam logic [3:0] ID_8  = 4'd8;
   localparam logic [3:0] ID_9  = 4'd9;
   localparam logic [3:0] ID_11 = 4'd11;

   localparam logic [3:0] OPC_2  = 4'b0111;
   localparam logic [3:0] OPC_4  = 4'b0101;
   localparam logic [3:0] OPC_8  = 4'b0000;
   localparam logic [3:0] OPC_9  = 4'b0001;
   localparam logic [3:0] OPC_11 = 4'b1110;

   localparam logic [1:0] CLASS_BASE = 2'b00;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} encode_state_t;

   function automatic logic is_legal_id(input logic [3:0] id);
      return (id == ID_2) || (id == ID_4) || (id == ID_8) ||
             (id == ID_9) || (id == ID_11);
   endfunction

   // Unknown IDs fall back to opcode 0000, the decoder's default.
   function automatic logic [7:0] encode_op(input logic [3:0] id, input logic d);
      logic [3:0] opc;
      case (id)
         ID_2:    opc = OPC_2;
         ID_4:    opc = OPC_4;
         ID_8:    opc = OPC_8;
         ID_9:    opc = OPC_9;
         ID_11:   opc = OPC_11;
         default: opc = OPC_8;
      endcase
      return {CLASS_BASE, opc, d, 1'b0};
   endfunction

endpackage

// File: rtl/inst_encode_if.sv
// Op stream in, memory write port and session status out of the program loader.
interface inst_encode_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic              op_valid;
   logic              op_ready;
   logic [3:0]        op_code;
   logic              op_d;
   logic              op_last;
   logic              wr_en;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              done;
   logic              busy;
   logic              err_illegal;
   logic              err_ovf;

   modport master (
      output start, op_valid, op_code, op_d, op_last, wr_ready,
      input  op_ready, wr_en, wr_addr, wr_data, done, busy, err_illegal, err_ovf
   );

   modport slave (
      input  start, op_valid, op_code, op_d, op_last, wr_ready,
      output op_ready, wr_en, wr_addr, wr_data, done, busy, err_illegal, err_ovf
   );
endinterface

// File: rtl/inst_fifo.sv
// Register-based FIFO whose head is presented straight out of storage; no output latency.
// Push ignored when full, pop ignored when empty; full blocks push even with a same-cycle pop.
module inst_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             one_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign one_o   = (cnt_q == CNT_W'(1));
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/inst_encode.sv
// Program loader: encodes op IDs into instruction bytes and writes them to memory from address 0.
// Op-to-write latency 1 cycle; op_ready drops while the FIFO is full; INST_ENCODE_CHECK_EN drops illegal IDs.
module inst_encode #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8
) (
   input logic          clk,
   input logic          rst_n,
   inst_encode_if.slave bus
);
   import inst_pkg::*;

   encode_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ovf_q, ovf_d;
   logic              fifo_full, fifo_empty, fifo_one;
   logic              op_rdy, op_hs, wr_hs, push, id_ok;
   logic [7:0]        enc_byte, head;

   assign op_rdy   = (state_q == LOAD) && !fifo_full;
   assign op_hs    = bus.op_valid && op_rdy;
   assign wr_hs    = !fifo_empty && bus.wr_ready;
   assign enc_byte = encode_op(bus.op_code, bus.op_d);
   assign push     = op_hs && id_ok;

`ifdef INST_ENCODE_CHECK_EN
   logic ill_q, ill_d;
   assign id_ok           = is_legal_id(bus.op_code);
   assign bus.err_illegal = ill_q;

   always_comb begin
      ill_d = ill_q;
      if (state_q == IDLE && bus.start) ill_d = 1'b0;
      else if (op_hs && !id_ok)         ill_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ill_q <= 1'b0;
      else        ill_q <= ill_d;
   end
`else
   assign id_ok           = 1'b1;
   assign bus.err_illegal = 1'b0;
`endif

   inst_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (enc_byte),
      .pop_i   (wr_hs),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .one_o   (fifo_one)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               addr_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD:  if (op_hs && bus.op_last) state_d = DRAIN;
         // Leaving on the final pop lets done land the cycle after the last write.
         DRAIN: if (fifo_empty || (fifo_one && wr_hs)) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (wr_hs) begin
         addr_d = addr_q + ADDR_W'(1);
         if (&addr_q) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.op_ready = op_rdy;
   assign bus.wr_en    = !fifo_empty;
   assign bus.wr_data  = head;
   assign bus.wr_addr  = addr_q;
   assign bus.done     = (state_q == DONE);
   assign bus.busy     = (state_q != IDLE);
   assign bus.err_ovf  = ovf_q;

endmodule

// File: tb/tb_inst_encode.sv
// Randomised sessions against a queue-based reference of the loader, plus the directed scenarios.
module tb_inst_encode;
   localparam int DEPTH = 4;
`ifdef INST_ENCODE_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   inst_encode_if #(.ADDR_W(8)) bus_a ();
   inst_encode_if #(.ADDR_W(2)) bus_w ();
   inst_encode #(.DEPTH(DEPTH), .ADDR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   inst_encode #(.DEPTH(DEPTH), .ADDR_W(2)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

   int n_cmp = 0;
   int n_mis = 0;

   int sel, addr_mod, cyc, done_due, m_phase, m_addr;
   bit m_busy, m_ovf, m_ill, saw_done;
   int exp_q[$];
   int wlog_data[$], wlog_addr[$];
   int s_id[$];
   bit s_d[$];
   int p_valid, p_wrr, stall_n, acc_stall;
   logic [31:0] o_ready, o_wen, o_done, o_busy, o_ill, o_ovf, o_waddr, o_wdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int ref_byte(input int id, input bit d);
      int opc;
      case (id)
         2:       opc = 7;
         4:       opc = 5;
         9:       opc = 1;
         11:      opc = 14;
         default: opc = 0;
      endcase
      return opc * 4 + (d ? 2 : 0);
   endfunction

   function automatic bit ref_legal(input int id);
      return id == 2 || id == 4 || id == 8 || id == 9 || id == 11;
   endfunction

   task automatic drive(input bit st, input bit v, input int code, input bit d, input bit last, input bit wrr);
      bus_a.start    = (sel == 0) && st;
      bus_a.op_valid = (sel == 0) && v;
      bus_a.op_code  = 4'(code);
      bus_a.op_d     = d;
      bus_a.op_last  = last;
      bus_a.wr_ready = (sel == 0) ? wrr : 1'b1;
      bus_w.start    = (sel == 1) && st;
      bus_w.op_valid = (sel == 1) && v;
      bus_w.op_code  = 4'(code);
      bus_w.op_d     = d;
      bus_w.op_last  = last;
      bus_w.wr_ready = (sel == 1) ? wrr : 1'b1;
   endtask

   task automatic sample();
      if (sel == 0) begin
         o_ready = 32'(bus_a.op_ready); o_wen  = 32'(bus_a.wr_en);
         o_done  = 32'(bus_a.done);     o_busy = 32'(bus_a.busy);
         o_ill   = 32'(bus_a.err_illegal); o_ovf = 32'(bus_a.err_ovf);
         o_waddr = 32'(bus_a.wr_addr);  o_wdata = 32'(bus_a.wr_data);
      end else begin
         o_ready = 32'(bus_w.op_ready); o_wen  = 32'(bus_w.wr_en);
         o_done  = 32'(bus_w.done);     o_busy = 32'(bus_w.busy);
         o_ill   = 32'(bus_w.err_illegal); o_ovf = 32'(bus_w.err_ovf);
         o_waddr = 32'(bus_w.wr_addr);  o_wdata = 32'(bus_w.wr_data);
      end
   endtask

   // One clock cycle, entered at posedge+1: check against the model, then apply this edge's events.
   task automatic step(input bit st, input bit v, input int code, input bit d, input bit last,
                       input bit wrr, output bit hs_op);
      int phase0;
      bit hs_wr;
      drive(st, v, code, d, last, wrr);
      sample();
      check_eq("op_ready", o_ready, 32'(m_phase == 1 && exp_q.size() < DEPTH));
      check_eq("wr_en", o_wen, 32'(exp_q.size() != 0));
      check_eq("busy", o_busy, 32'(m_busy));
      check_eq("done", o_done, 32'(cyc == done_due));
      check_eq("err_ovf", o_ovf, 32'(m_ovf));
      check_eq("err_illegal", o_ill, 32'(m_ill));
      if (o_done == 1) saw_done = 1'b1;
      if (o_wen == 1 && exp_q.size() != 0) begin
         check_eq("wr_data", o_wdata, 32'(exp_q[0]));
         check_eq("wr_addr", o_waddr, 32'(m_addr));
      end
      phase0 = m_phase;
      hs_wr  = (o_wen == 1) && wrr;
      hs_op  = v && (o_ready == 1);
      if (hs_wr && exp_q.size() != 0) begin
         wlog_data.push_back(int'(o_wdata));
         wlog_addr.push_back(int'(o_waddr));
         void'(exp_q.pop_front());
         if (m_addr == addr_mod - 1) begin
            m_addr = 0;
            m_ovf  = 1'b1;
         end else begin
            m_addr++;
         end
      end
      if (hs_op) begin
         if (ref_legal(code) || !CHECK) exp_q.push_back(ref_byte(code, d));
         else m_ill = 1'b1;
         if (last) m_phase = 2;
      end
      if (phase0 == 2 && exp_q.size() == 0) begin
         m_phase  = 3;
         done_due = cyc + 1;
      end
      if (cyc == done_due) begin
         m_phase = 0;
         m_busy  = 1'b0;
      end
      if (st && phase0 == 0) begin
         m_phase = 1; m_busy = 1'b1; m_addr = 0; m_ovf = 1'b0; m_ill = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 1);
      rst_n = 1'b0;
      #1;
      sample();
      check_eq("rst_op_ready", o_ready, 0);
      check_eq("rst_wr_en", o_wen, 0);
      check_eq("rst_wr_addr", o_waddr, 0);
      check_eq("rst_wr_data", o_wdata, 0);
      check_eq("rst_done", o_done, 0);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_err_illegal", o_ill, 0);
      check_eq("rst_err_ovf", o_ovf, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      exp_q.delete();
      m_phase = 0; m_busy = 1'b0; m_ovf = 1'b0; m_ill = 1'b0; m_addr = 0;
      done_due = -100;
   endtask

   task automatic run_session();
      int idx, id;
      bit hs, v, wrr, dd, st;
      saw_done = 1'b0;
      wlog_data.delete();
      wlog_addr.delete();
      acc_stall = -1;
      step(1, 0, 0, 0, 0, 1, hs);
      idx = 0;
      for (int k = 0; k < 400 && !saw_done; k++) begin
         if (k == stall_n) acc_stall = idx;
         v   = (idx < s_id.size()) && ($urandom_range(99) < p_valid);
         wrr = (k >= stall_n) && ($urandom_range(99) < p_wrr);
         st  = ($urandom_range(9) == 0);
         id  = (idx < s_id.size()) ? s_id[idx] : 0;
         dd  = (idx < s_id.size()) ? s_d[idx] : 1'b0;
         step(st, v, id, dd, idx == s_id.size() - 1, wrr, hs);
         if (hs) idx++;
      end
      check_eq("session_done_seen", 32'(saw_done), 1);
      step(0, 0, 0, 0, 0, 1, hs);
   endtask

   task automatic load_ops(input int n);
      int pick[5] = '{2, 4, 8, 9, 11};
      s_id.delete();
      s_d.delete();
      for (int i = 0; i < n; i++) begin
         s_id.push_back(($urandom_range(9) < 8) ? pick[$urandom_range(4)] : int'($urandom_range(15)));
         s_d.push_back(1'($urandom_range(1)));
      end
   endtask

   initial begin
      bit hs;
      sel = 0; addr_mod = 256; cyc = 0; done_due = -100;
      #2;
      do_reset();

      // basic sequence
      s_id = '{2, 4, 11}; s_d = '{1, 0, 1};
      p_valid = 100; p_wrr = 100; stall_n = 0;
      run_session();
      check_eq("basic_count", wlog_data.size(), 3);
      if (wlog_data.size() == 3) begin
         check_eq("basic_b0", wlog_data[0], 32'h1E);
         check_eq("basic_b1", wlog_data[1], 32'h14);
         check_eq("basic_b2", wlog_data[2], 32'h3A);
         check_eq("basic_a2", wlog_addr[2], 2);
      end

      // backpressure: memory stalled for 6 cycles with 6 ops offered
      load_ops(6);
      stall_n = 6;
      run_session();
      check_eq("bp_accepted_during_stall", acc_stall, 4);
      stall_n = 0;

      // illegal op ID 5
      s_id = '{5}; s_d = '{1};
      run_session();
      sample();
      check_eq("illegal_writes", wlog_data.size(), CHECK ? 0 : 1);
      check_eq("illegal_flag", o_ill, 32'(CHECK));
      if (wlog_data.size() == 1) check_eq("illegal_byte", wlog_data[0], 32'h02);

      // randomised sessions on the 8-bit address build
      for (int s = 0; s < 8; s++) begin
         load_ops(1 + $urandom_range(9));
         p_valid = 50 + $urandom_range(50);
         p_wrr   = 30 + $urandom_range(70);
         run_session();
      end

      // reset with three bytes queued
      step(1, 0, 0, 0, 0, 0, hs);
      for (int i = 0; i < 3; i++) step(0, 1, 9, 1'(i), 0, 0, hs);
      check_eq("queued_before_reset", exp_q.size(), 3);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 1, 2, 1, 0, 1, hs);

      // address wrap on the 2-bit build
      sel = 1; addr_mod = 4;
      do_reset();
      load_ops(5);
      p_valid = 100; p_wrr = 100;
      run_session();
      sample();
      check_eq("wrap_ovf", o_ovf, 1);
      if (wlog_addr.size() == 5) begin
         check_eq("wrap_a3", wlog_addr[3], 3);
         check_eq("wrap_a4", wlog_addr[4], 0);
      end
      for (int s = 0; s < 4; s++) begin
         load_ops(2 + $urandom_range(8));
         p_valid = 60 + $urandom_range(40);
         p_wrr   = 40 + $urandom_range(60);
         run_session();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
